// File: rtl/uart_frame_streamer.sv
// uart_frame_streamer
// Streams one camera frame over a byte-wide UART: an optional 7-byte header,
// WIDTH*HEIGHT pixels pulled from a fixed-latency FIFO (CH bytes each, MSB
// first, or only byte 0 in mono mode), then an 8-bit payload checksum.
// Every byte goes through the same SEND/WAIT_TX handshake with the UART.

module uart_frame_streamer #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int CH     = 3,
    parameter int RD_LAT = 2,
    parameter int HDR_EN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            mono,
    output logic            pix_rd_req,
    input  logic [8*CH-1:0] pix_data,
    output logic [7:0]      tx_data,
    output logic            tx_start,
    input  logic            tx_busy,
    input  logic            tx_done,
    output logic            busy,
    output logic            done,
    output logic            aborted,
    output logic [7:0]      checksum,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR     = 3'd1,
        S_REQ     = 3'd2,
        S_WAIT_RD = 3'd3,
        S_SEND    = 3'd4,
        S_WAIT_TX = 3'd5,
        S_CSUM    = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    // Which kind of byte the shared SEND/WAIT_TX handshake is carrying.
    typedef enum logic [1:0] {
        PH_HDR  = 2'd0,
        PH_PIX  = 2'd1,
        PH_CSUM = 2'd2
    } phase_t;

    localparam longint          TOTAL    = longint'(WIDTH) * longint'(HEIGHT);
    localparam int              CNT_W    = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(TOTAL - 1);
    localparam logic [15:0]     W16      = 16'(WIDTH);
    localparam logic [15:0]     H16      = 16'(HEIGHT);
    localparam logic [2:0]      LAT3     = 3'(RD_LAT);
    localparam logic [2:0]      CH_M1    = 3'(CH - 1);
    localparam logic [7:0]      CH8      = 8'(CH);

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic              mono_q, mono_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [2:0]        byte_idx_q, byte_idx_d;
    logic [2:0]        lat_cnt_q, lat_cnt_d;
    logic [8*CH-1:0]   pix_q, pix_d;
    logic [7:0]        checksum_q, checksum_d;
    logic              aborted_q, aborted_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_start_q, tx_start_d;
    logic              pix_rd_req_q, pix_rd_req_d;

    logic [7:0]        hdr_byte;
    logic [7:0]        pix_byte;
    logic [7:0]        cur_byte;
    logic              last_byte;
    logic              tx_ack;

    // Header byte selected by the running byte index.
    always_comb begin
        hdr_byte = 8'h00;
        case (byte_idx_q)
            3'd0:    hdr_byte = 8'hA5;
            3'd1:    hdr_byte = 8'h5A;
            3'd2:    hdr_byte = W16[15:8];
            3'd3:    hdr_byte = W16[7:0];
            3'd4:    hdr_byte = H16[15:8];
            3'd5:    hdr_byte = H16[7:0];
            3'd6:    hdr_byte = mono_q ? 8'd1 : CH8;
            default: hdr_byte = 8'h00;
        endcase
    end

    // Pixel byte: index 0 is the most significant byte; mono sends bits 7:0 only.
    always_comb begin
        pix_byte = pix_q[7:0];
        if (!mono_q) begin
            for (int k = 0; k < CH; k++) begin
                if (byte_idx_q == 3'(k)) begin
                    pix_byte = pix_q[8*(CH-1-k) +: 8];
                end
            end
        end
    end

    // Byte offered to the UART and end-of-pixel / handshake qualifiers.
    always_comb begin
        case (phase_q)
            PH_HDR:  cur_byte = hdr_byte;
            PH_PIX:  cur_byte = pix_byte;
            default: cur_byte = checksum_q;
        endcase
        last_byte = mono_q || (byte_idx_q == CH_M1);
        // A completion pulse in the same cycle as our own request belongs to
        // an earlier byte, so it is not taken as the acknowledge.
        tx_ack    = tx_done && !tx_start_q;
    end

    // Next-state and datapath updates; abort overrides everything at the end.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        mono_d       = mono_q;
        pix_cnt_d    = pix_cnt_q;
        byte_idx_d   = byte_idx_q;
        lat_cnt_d    = lat_cnt_q;
        pix_d        = pix_q;
        checksum_d   = checksum_q;
        aborted_d    = aborted_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        pix_rd_req_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mono_d     = mono;
                    pix_cnt_d  = '0;
                    byte_idx_d = 3'd0;
                    checksum_d = 8'h00;
                    aborted_d  = 1'b0;
                    if (HDR_EN != 0) begin
                        state_d = S_HDR;
                        phase_d = PH_HDR;
                    end else begin
                        state_d      = S_REQ;
                        phase_d      = PH_PIX;
                        pix_rd_req_d = 1'b1;
                    end
                end
            end
            S_HDR: begin
                state_d = S_SEND;
            end
            S_REQ: begin
                state_d   = S_WAIT_RD;
                lat_cnt_d = 3'd1;
            end
            S_WAIT_RD: begin
                if (lat_cnt_q == LAT3) begin
                    pix_d   = pix_data;
                    state_d = S_SEND;
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    tx_data_d  = cur_byte;
                    tx_start_d = 1'b1;
                    state_d    = S_WAIT_TX;
                end
            end
            S_WAIT_TX: begin
                if (tx_ack) begin
                    case (phase_q)
                        PH_HDR: begin
                            if (byte_idx_q == 3'd6) begin
                                byte_idx_d   = 3'd0;
                                phase_d      = PH_PIX;
                                state_d      = S_REQ;
                                pix_rd_req_d = 1'b1;
                            end else begin
                                byte_idx_d = byte_idx_q + 3'd1;
                                state_d    = S_HDR;
                            end
                        end
                        PH_PIX: begin
                            checksum_d = checksum_q + tx_data_q;
                            if (last_byte) begin
                                byte_idx_d = 3'd0;
                                pix_cnt_d  = pix_cnt_q + 1'b1;
                                if (pix_cnt_q == LAST_PIX) begin
                                    phase_d = PH_CSUM;
                                    state_d = S_CSUM;
                                end else begin
                                    state_d      = S_REQ;
                                    pix_rd_req_d = 1'b1;
                                end
                            end else begin
                                byte_idx_d = byte_idx_q + 3'd1;
                                state_d    = S_SEND;
                            end
                        end
                        default: begin
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_CSUM: begin
                state_d = S_SEND;
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            aborted_d    = 1'b1;
            tx_start_d   = 1'b0;
            pix_rd_req_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            phase_q      <= PH_HDR;
            mono_q       <= 1'b0;
            pix_cnt_q    <= '0;
            byte_idx_q   <= 3'd0;
            lat_cnt_q    <= 3'd0;
            pix_q        <= '0;
            checksum_q   <= 8'h00;
            aborted_q    <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_start_q   <= 1'b0;
            pix_rd_req_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            mono_q       <= mono_d;
            pix_cnt_q    <= pix_cnt_d;
            byte_idx_q   <= byte_idx_d;
            lat_cnt_q    <= lat_cnt_d;
            pix_q        <= pix_d;
            checksum_q   <= checksum_d;
            aborted_q    <= aborted_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            pix_rd_req_q <= pix_rd_req_d;
        end
    end

    assign pix_rd_req = pix_rd_req_q;
    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign aborted    = aborted_q;
    assign checksum   = checksum_q;
    assign state      = state_q;

endmodule

// File: tb/tb_uart_frame_streamer.sv
// tb_uart_frame_streamer
// Three streamer instances (2x2 RGB with RD_LAT 2, 2x2 RGB with RD_LAT 5,
// 1x1 single-byte without header) driven by one directed sequence. Each has
// a FIFO model that presents its word only in the capture cycle and a UART
// model that stays busy for 10 cycles per byte.

module tb_uart_frame_streamer;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_SEND = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start [3];
    logic        abort_s [3];
    logic        mono_s [3];
    logic        rd_req [3];
    logic        tx_start [3];
    logic        tx_busy [3];
    logic        tx_done [3];
    logic        busy_o [3];
    logic        done_o [3];
    logic        aborted_o [3];
    logic [7:0]  tx_data [3];
    logic [7:0]  csum [3];
    logic [2:0]  st [3];
    logic [31:0] pd [3];

    // Bench-side models
    int          lat [3] = '{2, 5, 1};
    int          bcnt [3];
    logic        hold_busy [3];
    int          cd [3];
    logic [31:0] cur [3];
    int          rd_cnt [3];
    int          rd_base [3];
    int          rx_n [3];
    int          viol [3];
    logic [7:0]  rx_mem [3][256];

    logic [7:0] exp_rgb [20] = '{8'hA5, 8'h5A, 8'h00, 8'h02, 8'h00, 8'h02, 8'h03,
                                 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                                 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h4E};
    logic [7:0] exp_mono [12] = '{8'hA5, 8'h5A, 8'h00, 8'h02, 8'h00, 8'h02, 8'h01,
                                  8'h03, 8'h06, 8'h09, 8'h0C, 8'h1E};
    logic [7:0] exp_c [2] = '{8'hFF, 8'hFF};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_frame_streamer #(.WIDTH(2), .HEIGHT(2), .CH(3), .RD_LAT(2), .HDR_EN(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort_s[0]), .mono(mono_s[0]),
        .pix_rd_req(rd_req[0]), .pix_data(pd[0][23:0]), .tx_data(tx_data[0]),
        .tx_start(tx_start[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]),
        .busy(busy_o[0]), .done(done_o[0]), .aborted(aborted_o[0]),
        .checksum(csum[0]), .state(st[0]));

    uart_frame_streamer #(.WIDTH(2), .HEIGHT(2), .CH(3), .RD_LAT(5), .HDR_EN(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort_s[1]), .mono(mono_s[1]),
        .pix_rd_req(rd_req[1]), .pix_data(pd[1][23:0]), .tx_data(tx_data[1]),
        .tx_start(tx_start[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]),
        .busy(busy_o[1]), .done(done_o[1]), .aborted(aborted_o[1]),
        .checksum(csum[1]), .state(st[1]));

    uart_frame_streamer #(.WIDTH(1), .HEIGHT(1), .CH(1), .RD_LAT(1), .HDR_EN(0)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort_s[2]), .mono(mono_s[2]),
        .pix_rd_req(rd_req[2]), .pix_data(pd[2][7:0]), .tx_data(tx_data[2]),
        .tx_start(tx_start[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]),
        .busy(busy_o[2]), .done(done_o[2]), .aborted(aborted_o[2]),
        .checksum(csum[2]), .state(st[2]));

    function automatic logic [31:0] word_of(input int i, input int k);
        if (i == 2) return 32'h0000_00FF;
        return {8'h00, 8'(3*k + 1), 8'(3*k + 2), 8'(3*k + 3)};
    endfunction

    // UART busy line and FIFO output: word visible only RD_LAT cycles after the request.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            tx_busy[i] = (bcnt[i] != 0) || hold_busy[i];
            pd[i]      = (cd[i] == 1) ? cur[i] : 32'h00BE_ADDE;
        end
    end

    // UART and FIFO behaviour, plus byte capture and pulse counting.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                bcnt[i]    <= 0;
                tx_done[i] <= 1'b0;
                cd[i]      <= 0;
            end else begin
                tx_done[i] <= (bcnt[i] == 1);
                if (tx_start[i]) begin
                    if (tx_busy[i]) viol[i] <= viol[i] + 1;
                    bcnt[i] <= 10;
                    if (rx_n[i] < 256) rx_mem[i][rx_n[i]] <= tx_data[i];
                    rx_n[i] <= rx_n[i] + 1;
                end else if (bcnt[i] != 0) begin
                    bcnt[i] <= bcnt[i] - 1;
                end
                if (rd_req[i]) begin
                    cd[i]     <= lat[i];
                    cur[i]    <= word_of(i, (rd_cnt[i] - rd_base[i]) % 4);
                    rd_cnt[i] <= rd_cnt[i] + 1;
                end else if (cd[i] != 0) begin
                    cd[i] <= cd[i] - 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input int i, input logic [2:0] s, input int budget);
        int n = 0;
        while (st[i] !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("inst%0d reach state %0d", i, s), 32'(st[i]), 32'(s));
    endtask

    task automatic check_stream(input int i, input int base, input int n, input int which);
        logic [7:0] e;
        chk($sformatf("inst%0d byte count", i), 32'(rx_n[i] - base), 32'(n));
        for (int k = 0; k < n; k++) begin
            case (which)
                0:       e = exp_rgb[k];
                1:       e = exp_mono[k];
                default: e = exp_c[k];
            endcase
            chk($sformatf("inst%0d byte%0d", i, k), 32'(rx_mem[i][base + k]), 32'(e));
            $display("inst%0d byte%0d = %02h", i, k, rx_mem[i][base + k]);
        end
    endtask

    // Run one full frame on instance i and check the stream, checksum and read count.
    task automatic run_frame(input int i, input logic m, input int n, input int which,
                             input logic [7:0] exp_sum);
        int base;
        base       = rx_n[i];
        rd_base[i] = rd_cnt[i];
        mono_s[i]  = m;
        start[i]   = 1'b1;
        @(negedge clk);
        start[i]   = 1'b0;
        wait_state(i, ST_DONE, 3000);
        chk($sformatf("inst%0d done", i), 32'(done_o[i]), 32'd1);
        chk($sformatf("inst%0d checksum", i), 32'(csum[i]), 32'(exp_sum));
        chk($sformatf("inst%0d rd_req pulses", i), 32'(rd_cnt[i] - rd_base[i]),
            (which == 2) ? 32'd1 : 32'd4);
        check_stream(i, base, n, which);
        @(negedge clk);
        chk($sformatf("inst%0d back to idle", i), 32'(st[i]), 32'(ST_IDLE));
    endtask

    initial begin
        int base;
        int snap_tx;
        int snap_rd;
        int n;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0; abort_s[i] = 1'b0; mono_s[i] = 1'b0; hold_busy[i] = 1'b0;
            rd_cnt[i] = 0; rd_base[i] = 0; rx_n[i] = 0; viol[i] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset values
        chk("reset tx_data", 32'(tx_data[0]), 32'h0);
        chk("reset tx_start", 32'(tx_start[0]), 32'h0);
        chk("reset pix_rd_req", 32'(rd_req[0]), 32'h0);
        chk("reset busy", 32'(busy_o[0]), 32'h0);
        chk("reset done", 32'(done_o[0]), 32'h0);
        chk("reset aborted", 32'(aborted_o[0]), 32'h0);
        chk("reset checksum", 32'(csum[0]), 32'h0);
        chk("reset state", 32'(st[0]), 32'(ST_IDLE));

        // RGB frame, then the same frame in mono mode
        run_frame(0, 1'b0, 20, 0, 8'h4E);
        run_frame(0, 1'b1, 12, 1, 8'h1E);

        // UART busy for 50 cycles when the frame starts
        hold_busy[0] = 1'b1;
        base       = rx_n[0];
        rd_base[0] = rd_cnt[0];
        mono_s[0]  = 1'b0;
        start[0]   = 1'b1;
        @(negedge clk);
        chk("start goes to HDR", 32'(st[0]), 32'(ST_HDR));
        chk("busy during frame", 32'(busy_o[0]), 32'd1);
        start[0] = 1'b0;
        repeat (50) @(negedge clk);
        chk("no byte while busy", 32'(rx_n[0] - base), 32'd0);
        chk("held in SEND", 32'(st[0]), 32'(ST_SEND));
        hold_busy[0] = 1'b0;
        wait_state(0, ST_DONE, 3000);
        chk("busy frame checksum", 32'(csum[0]), 32'h4E);
        check_stream(0, base, 20, 0);
        @(negedge clk);

        // Long read latency instance
        run_frame(1, 1'b0, 20, 0, 8'h4E);

        // Abort during the second byte of the first pixel
        base       = rx_n[0];
        rd_base[0] = rd_cnt[0];
        start[0]   = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        n = 0;
        while (rx_n[0] - base < 9 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reached abort point", 32'(rx_n[0] - base), 32'd9);
        abort_s[0] = 1'b1;
        @(negedge clk);
        abort_s[0] = 1'b0;
        chk("abort state", 32'(st[0]), 32'(ST_IDLE));
        chk("abort flag", 32'(aborted_o[0]), 32'd1);
        chk("abort busy", 32'(busy_o[0]), 32'd0);
        chk("abort tx_start", 32'(tx_start[0]), 32'd0);
        snap_tx = rx_n[0];
        snap_rd = rd_cnt[0];
        repeat (40) @(negedge clk);
        chk("no tx_start after abort", 32'(rx_n[0]), 32'(snap_tx));
        chk("no rd_req after abort", 32'(rd_cnt[0]), 32'(snap_rd));
        chk("aborted sticky", 32'(aborted_o[0]), 32'd1);
        base       = rx_n[0];
        rd_base[0] = rd_cnt[0];
        start[0]   = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        chk("aborted cleared", 32'(aborted_o[0]), 32'd0);
        chk("restart HDR", 32'(st[0]), 32'(ST_HDR));
        wait_state(0, ST_DONE, 3000);
        check_stream(0, base, 20, 0);
        @(negedge clk);

        // 1x1 single-byte frame, no header, start held high through DONE
        base       = rx_n[2];
        rd_base[2] = rd_cnt[2];
        start[2]   = 1'b1;
        wait_state(2, ST_DONE, 500);
        chk("c checksum", 32'(csum[2]), 32'hFF);
        chk("c rd_req pulses", 32'(rd_cnt[2] - rd_base[2]), 32'd1);
        check_stream(2, base, 2, 2);
        repeat (20) @(negedge clk);
        chk("c holds DONE", 32'(st[2]), 32'(ST_DONE));
        chk("c done high", 32'(done_o[2]), 32'd1);
        chk("c no restart", 32'(rx_n[2] - base), 32'd2);
        start[2] = 1'b0;
        @(negedge clk);
        chk("c idle after start low", 32'(st[2]), 32'(ST_IDLE));

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("inst%0d tx_start while busy", i), 32'(viol[i]), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_streamer.md
# uart_frame_streamer

Parametrised frame-to-UART streamer for the camera capture path. On a start request it emits a framed header, pulls WIDTH×HEIGHT pixels one word at a time from the SDRAM read-side FIFO (fixed read latency), and serialises each pixel as CH bytes (or 1 byte in mono mode) to the UART transmitter. It appends an 8-bit payload checksum and supports mid-frame abort. It supersedes the fixed 640×480 / 3-byte sender in the UART communication path.

## Interface
- WIDTH, 640, pixels per line (1..65535)
- HEIGHT, 480, lines per frame (1..65535)
- CH, 3, bytes per pixel word (1..4); pix_data width = 8*CH
- RD_LAT, 2, cycles from pix_rd_req to valid pix_data (1..7)
- HDR_EN, 1, 1 = send 7-byte header before payload
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  level; frame begins when high in IDLE
- abort  in  1  level; terminates the frame from any non-IDLE state
- mono  in  1  sampled at frame start; 1 = send only byte 0 of each pixel
- pix_rd_req  out  1  one-cycle FIFO read strobe
- pix_data  in  8*CH  pixel word from FIFO
- tx_data  out  8  byte to UART
- tx_start  out  1  one-cycle transmit request
- tx_busy  in  1  UART transmitter busy
- tx_done  in  1  one-cycle pulse, byte finished
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE
- aborted  out  1  sticky; set by abort, cleared on next frame start
- checksum  out  8  running payload sum
- state  out  3  debug state code

## Operation
- States: IDLE(0), HDR(1), REQ(2), WAIT_RD(3), SEND(4), WAIT_TX(5), CSUM(6), DONE(7).
- IDLE: start=1 → latch mono, clear pixel counter, byte index, checksum and aborted; go to HDR if HDR_EN, else REQ.
- Header bytes, in order: 0xA5, 0x5A, WIDTH[15:8], WIDTH[7:0], HEIGHT[15:8], HEIGHT[7:0], BPP (1 if mono, else CH). Header bytes are not added to the checksum.
- REQ: pix_rd_req=1 for exactly this cycle → WAIT_RD.
- WAIT_RD: count RD_LAT cycles, capture pix_data into the pixel register on the last one, then go to SEND.
- Byte order per pixel: most significant byte first (bits 8*CH-1..8*CH-8 first); in mono mode only bits 7:0 are sent.
- SEND: when tx_busy=0, load tx_data, pulse tx_start and go to WAIT_TX; otherwise hold in SEND.
- WAIT_TX: on tx_done, add the byte to the checksum (mod 256, payload only). Then:
  - more bytes of this pixel remain → SEND;
  - last byte of pixel and pixels remain → REQ;
  - last byte of last pixel → CSUM.
- The header uses the same SEND/WAIT_TX handshake. HDR sequences through the 7 bytes, then goes to REQ.
- CSUM: sends the checksum byte via the same handshake, then goes to DONE.
- DONE: done=1; hold while start=1; start=0 → IDLE.
- abort=1 in any non-IDLE state → IDLE on the next edge, aborted=1, tx_start=0, no further pix_rd_req. Abort has priority over every other transition, including DONE. A UART byte already in flight completes on its own; a new frame waits in SEND until tx_busy=0.
- Pixel counter width: $clog2(WIDTH*HEIGHT+1); counts pixels fully sent.

## Timing
- Reset values: tx_data=0, tx_start=0, pix_rd_req=0, busy=0, done=0, aborted=0, checksum=0, state=IDLE.
- pix_rd_req is asserted in cycle n (state REQ); pix_data is captured on the edge ending cycle n+RD_LAT.
- tx_start: single-cycle, registered; tx_data is valid in the same cycle and held until the next byte is loaded.
- tx_done is ignored outside WAIT_TX. A tx_done coincident with tx_start is not accepted.
- Minimum per byte: 2 cycles plus UART time. Minimum per pixel adds 1+RD_LAT cycles.
- IDLE→HDR or REQ: 1 cycle after start is sampled high.
- start held high after DONE does not restart the frame.
- rst_n low mid-frame returns to reset values on the next edge, regardless of tx_busy.

## Test plan
- WIDTH=2, HEIGHT=2, CH=3, RD_LAT=2, HDR_EN=1; FIFO words 0x010203, 0x040506, 0x070809, 0x0A0B0C; UART model 10-cycle busy → stream is A5 5A 00 02 00 02 03, then 01..0C, then checksum 0x4E; done=1; exactly 4 pix_rd_req pulses.
- Same frame with mono=1 → BPP byte 01; payload 03 06 09 0C; checksum 0x1E.
- tx_busy held high for 50 cycles at frame start → no tx_start until tx_busy falls; the first byte is still A5; no bytes lost.
- RD_LAT=5 → pixel register loads exactly 5 cycles after each pix_rd_req; no earlier FIFO value is ever sent.
- abort asserted during the 2nd byte of pixel 1 → IDLE next edge, aborted=1, no further tx_start or pix_rd_req. A new start → aborted clears and the header restarts from A5.
- HDR_EN=0, WIDTH=1, HEIGHT=1, CH=1, word 0xFF → stream FF FF (payload, then checksum); done=1; start held high → remains in DONE.
